// File: rtl/io_bridge.sv
// io_bridge: CPU IO request to one-hot peripheral slot bridge with wait states and timeout.
module io_bridge #(
  parameter int ADDR_W = 14,
  parameter int NSLOT = 8,
  parameter int SLOT_LSB = 4,
  parameter logic [NSLOT-1:0] SLOT_EN = '1,
  parameter int TMO = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dbe_i,
  input  logic                  io_req_i,
  input  logic                  io_we_i,
  input  logic                  io_re_i,
  input  logic [ADDR_W-1:0]     io_addr_i,
  input  logic [31:0]           io_wd_i,
  output logic [31:0]           io_rd_o,
  output logic                  io_busy_o,
  output logic                  io_done_o,
  output logic                  io_err_o,
  output logic [NSLOT-1:0]      s_sel_o,
  output logic                  s_we_o,
  output logic                  s_re_o,
  output logic [SLOT_LSB-1:0]   s_a_o,
  output logic [31:0]           s_wd_o,
  input  logic [32*NSLOT-1:0]   s_rd_i,
  input  logic [NSLOT-1:0]      s_ack_i
);
  localparam int SW = $clog2(NSLOT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d, slot_in;
  logic [SLOT_LSB-1:0] off_q, off_d;
  logic [31:0] wd_q, wd_d, rd_q, rd_d, rd_sel;
  logic we_q, we_d, err_q, err_d, acc, ack, act;
  logic [7:0] cnt_q, cnt_d;
  assign slot_in = io_addr_i[SLOT_LSB+SW-1:SLOT_LSB];
  assign acc = io_req_i & ~dbe_i & (io_we_i | io_re_i);
  assign ack = s_ack_i[slot_q];
  assign rd_sel = s_rd_i[{slot_q, 5'd0} +: 32];
  assign act = (state_q == ISSUE) || (state_q == WAIT);
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    off_d = off_q;
    wd_d = wd_q;
    we_d = we_q;
    rd_d = rd_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (acc) begin
        slot_d = slot_in;
        off_d = io_addr_i[SLOT_LSB-1:0];
        wd_d = io_wd_i;
        we_d = io_we_i;
        rd_d = '0;
        err_d = ~SLOT_EN[slot_in];
        cnt_d = '0;
        state_d = SLOT_EN[slot_in] ? ISSUE : DONE;
      end
      ISSUE: begin
        state_d = ack ? DONE : WAIT;
        rd_d = (ack && !we_q) ? rd_sel : rd_q;
        cnt_d = 8'd1;
      end
      WAIT: begin
        // an ack arriving on the timeout cycle still completes cleanly
        state_d = (ack || cnt_q == 8'(TMO)) ? DONE : WAIT;
        rd_d = (ack && !we_q) ? rd_sel : rd_q;
        err_d = !ack && cnt_q == 8'(TMO);
        cnt_d = cnt_q + 8'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_q <= '0;
      off_q <= '0;
      wd_q <= '0;
      we_q <= 1'b0;
      rd_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      off_q <= off_d;
      wd_q <= wd_d;
      we_q <= we_d;
      rd_q <= rd_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign io_rd_o = rd_q;
  assign io_busy_o = act;
  assign io_done_o = state_q == DONE;
  assign io_err_o = (state_q == DONE) && err_q;
  assign s_sel_o = act ? {{(NSLOT-1){1'b0}}, 1'b1} << slot_q : '0;
  assign s_we_o = (state_q == ISSUE) && we_q;
  assign s_re_o = (state_q == ISSUE) && !we_q;
  assign s_a_o = off_q;
  assign s_wd_o = wd_q;
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: randomized transactions against a per-access latency/result model.
module tb_io_bridge;
  localparam int TMO = 15;
  localparam logic [7:0] EN = 8'h7F;
  logic clk = 0, rst = 1, dbe = 0, req = 0, we = 0, re = 0;
  logic [13:0] addr = '0;
  logic [31:0] wd = '0, rd, swd;
  logic busy, done, err, swe, sre;
  logic [7:0] sel, ack = '0;
  logic [3:0] sa;
  logic [255:0] srd = '0;
  int checks = 0, failures = 0;

  io_bridge #(.ADDR_W(14), .NSLOT(8), .SLOT_LSB(4), .SLOT_EN(EN), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .dbe_i(dbe), .io_req_i(req), .io_we_i(we), .io_re_i(re),
    .io_addr_i(addr), .io_wd_i(wd), .io_rd_o(rd), .io_busy_o(busy), .io_done_o(done),
    .io_err_o(err), .s_sel_o(sel), .s_we_o(swe), .s_re_o(sre), .s_a_o(sa), .s_wd_o(swd),
    .s_rd_i(srd), .s_ack_i(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_we"}, swe, 0);
    chk({tag, "_re"}, sre, 0);
  endtask

  // d = ack delay in cycles after the ISSUE cycle; d > TMO means the slot never answers in time
  task automatic txn(input int slot, input logic w, input logic r, input logic [31:0] data,
                     input logic [31:0] rdv, input int d, input bit hold);
    logic pop, ok, act, wr;
    int lat;
    logic [31:0] erd;
    logic [7:0] oh;
    logic [3:0] off;
    pop = EN[slot];
    wr = w;
    oh = 8'(1) << slot;
    ok = pop && d <= TMO;
    lat = !pop ? 1 : ok ? 2 + d : TMO + 2;
    for (int k = 0; k < 8; k++) srd[32*k +: 32] = $urandom;
    srd[32*slot +: 32] = rdv;
    erd = (ok && !wr) ? rdv : 32'h0;
    off = 4'($urandom);
    @(negedge clk);
    req = 1; we = w; re = r; wd = data;
    addr = {7'($urandom), 3'(slot), off};
    ack = 8'($urandom) & ~oh;
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (!hold) begin
        req = 0;
        addr = 14'($urandom);
        wd = $urandom;
      end
      act = pop && c < lat;
      chk("done", done, c == lat);
      chk("busy", busy, act);
      chk("sel", sel, act ? oh : 8'h0);
      chk("s_we", swe, act && c == 1 && wr);
      chk("s_re", sre, act && c == 1 && !wr);
      if (act) begin
        chk("s_a", sa, off);
        chk("s_wd", swd, data);
      end
      if (c == lat) begin
        chk("err", err, !ok);
        chk("rd", rd, erd);
      end
      ack = (8'($urandom) & ~oh) | ((pop && c - 1 == d) ? oh : 8'h0);
    end
  endtask

  initial begin
    #2;
    chk("rst_rd", rd, 0);
    chk("rst_err", err, 0);
    chk("rst_a", sa, 0);
    chk("rst_wd", swd, 0);
    idle_chk("rst");
    @(negedge clk);
    rst = 0;
    txn(1, 0, 1, 32'h0, 32'hCAFE0001, 0, 0);
    txn(3, 1, 0, 32'h5A, $urandom, 4, 0);
    txn(7, 0, 1, 32'h0, $urandom, 0, 0);
    txn(0, 0, 1, 32'h0, $urandom, 255, 0);
    txn(2, 1, 1, $urandom, $urandom, TMO, 0);
    txn(4, 0, 1, $urandom, $urandom, TMO, 0);
    txn(6, 0, 1, $urandom, $urandom, TMO + 1, 0);
    txn(5, 0, 1, $urandom, $urandom, 2, 1);
    txn(5, 1, 0, $urandom, $urandom, 1, 1);
    txn(1, 0, 1, $urandom, $urandom, 0, 0);
    @(negedge clk);
    req = 1; dbe = 1; we = 1; re = 1; addr = 14'h0020;
    repeat (2) begin
      @(negedge clk);
      idle_chk("dbe");
    end
    dbe = 0; we = 0; re = 0;
    repeat (2) begin
      @(negedge clk);
      idle_chk("noqual");
    end
    req = 0;
    for (int i = 0; i < 40; i++) begin
      logic w, r;
      int d;
      w = 1'($urandom);
      r = 1'($urandom) | ~w;
      d = ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, TMO + 2);
      txn($urandom_range(0, 7), w, r, $urandom, $urandom, d, 1'($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    req = 1; we = 0; re = 1; wd = 32'h1234; addr = {7'h0, 3'd2, 4'hA}; ack = '0;
    @(negedge clk);
    req = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1;
    #1;
    chk("arst_rd", rd, 0);
    chk("arst_err", err, 0);
    chk("arst_a", sa, 0);
    chk("arst_wd", swd, 0);
    idle_chk("arst");
    repeat (2) @(negedge clk);
    idle_chk("hold_rst");
    rst = 0;
    txn(2, 0, 1, $urandom, 32'hBEEF0042, 3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, IO word-address width.
REQ-002 SHALL have parameter NSLOT, default 8, number of peripheral slots (power of 2, 2..16).
REQ-003 SHALL have parameter SLOT_LSB, default 4, lowest address bit of slot index; slot = IO_ADDR[SLOT_LSB+log2(NSLOT)-1:SLOT_LSB], offset = IO_ADDR[SLOT_LSB-1:0].
REQ-004 SHALL have parameter SLOT_EN, default all ones (NSLOT bits), mask of populated slots.
REQ-005 SHALL have parameter TMO, default 15, wait-state timeout in cycles (1..255).
REQ-006 CLK  in  1  single clock; all state on rising edge.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 DBE  in  1  CPU data-bus-error flag; a request with DBE=1 is dropped.
REQ-009 IO_REQ  in  1  CPU IO access request, sampled only in IDLE.
REQ-010 IO_WE / IO_RE  in  1 each  write / read qualifiers.
REQ-011 IO_ADDR  in  ADDR_W  word address.   IO_WD  in  32  write data.
REQ-012 IO_RD  out  32  registered read data, valid while IO_DONE=1.
REQ-013 IO_BUSY  out  1  CPU stall; high from the cycle after accept until IO_DONE.
REQ-014 IO_DONE  out  1  one-cycle completion pulse.   IO_ERR  out  1  qualifies IO_DONE with error.
REQ-015 S_SEL  out  NSLOT  one-hot slot select, held for the whole access.
REQ-016 S_WE / S_RE  out  1 each  one-cycle strobes in ISSUE state.
REQ-017 S_A  out  SLOT_LSB  offset.   S_WD  out  32  write data, held for the access.
REQ-018 S_RD  in  32*NSLOT  per-slot read data, slot k at bits [32k+31:32k].
REQ-019 S_ACK  in  NSLOT  per-slot completion; a slot may ack in the ISSUE cycle (zero wait).

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-021 IDLE: on IO_REQ=1 & DBE=0 & (IO_WE|IO_RE) SHALL register addr, WD, WE, RE and go to ISSUE; otherwise stay; IO_WE and IO_RE both 1 SHALL be treated as write.
REQ-022 Unpopulated slot (SLOT_EN bit 0): SHALL skip ISSUE/WAIT, go directly to DONE with IO_RD=0, IO_ERR=1; no S_* strobe.
REQ-023 ISSUE: SHALL assert S_SEL, S_WE or S_RE for exactly one cycle; if selected S_ACK=1 same cycle go to DONE, else WAIT.
REQ-024 WAIT: SHALL hold S_SEL/S_A/S_WD, strobes low; 8-bit counter from 1 increments per cycle; on selected S_ACK go DONE; when counter reaches TMO without ack go DONE with IO_ERR=1, IO_RD=0.
REQ-025 S_ACK on non-selected slots SHALL be ignored; ack and timeout in same cycle SHALL count as ack (no error).
REQ-026 On read ack, selected slot's S_RD SHALL be captured into IO_RD register on that edge; writes SHALL leave IO_RD=0.
REQ-027 DONE: IO_DONE=1 one cycle, IO_BUSY=0, S_SEL=0; next state IDLE; IO_REQ in DONE SHALL be ignored.
REQ-028 Latency: zero-wait access SHALL give IO_DONE 2 cycles after accept edge; each wait cycle adds 1; max TMO+2.
REQ-029 Back-to-back: a new request SHALL be accepted in the IDLE cycle following DONE (min 3-cycle period).

Reset
REQ-030 RESET=1 SHALL force IDLE asynchronously, counter=0, IO_RD=0, IO_BUSY=0, IO_DONE=0, IO_ERR=0, S_SEL=0, S_WE=0, S_RE=0, S_A=0, S_WD=0.
REQ-031 Reset mid-access SHALL abort with no IO_DONE; the first request after deassertion SHALL be accepted normally.

Verification
REQ-032 Read slot 1 offset 2, S_ACK[1] in ISSUE, S_RD slot1=0xCAFE0001 -> S_SEL=0x02, S_RE 1 cycle, IO_DONE 2 cycles after accept, IO_RD=0xCAFE0001, IO_ERR=0.
REQ-033 Write 0x5A to slot 3, ack after 4 wait cycles -> S_WD=0x5A held 5 cycles, single S_WE pulse, IO_DONE at accept+6, IO_ERR=0.
REQ-034 SLOT_EN=0x7F, read slot 7 -> no S_SEL, IO_DONE at accept+1, IO_ERR=1, IO_RD=0.
REQ-035 Read slot 0, never ack, TMO=15 -> IO_DONE with IO_ERR=1 exactly 17 cycles after accept; spurious S_ACK[2] during wait ignored.
REQ-036 IO_REQ with DBE=1 -> no state change, no strobes; IO_REQ held through access -> second access starts only after DONE.
REQ-037 RESET asserted in WAIT -> all outputs zero immediately, no IO_DONE; next read completes correctly.
